// File: rtl/debounced_input.sv
// debounced_input: samples an iCE40 package pin through an SB_IO in input
// mode, synchronizes it into the clk domain, debounces it, and reports
// one-cycle rise/fall strobes registered together with the level.
//
// Configuration macro: DEBOUNCED_INPUT_PULLUP_EN
//   defined   -> SB_IO weak internal pull-up enabled (floating pin reads 1)
//   undefined -> no pull-up; the pin must be driven externally
// The SB_IO primitive is instantiated when the file is read by yosys; other
// tools see a direct wire from the pin, which is the unregistered input path.
module debounced_input #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic INIT_VALUE      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic value,
    output logic rise,
    output logic fall
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject illegal configurations at elaboration.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounced_input: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("debounced_input: DEBOUNCE_CYCLES must be >= 1");
    end

    logic                   w_pin_in;
    logic                   w_sync;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_value;
    logic                   r_rise;
    logic                   r_fall;

`ifdef YOSYS
`ifdef DEBOUNCED_INPUT_PULLUP_EN
    localparam logic P_PULLUP = 1'b1;
`else
    localparam logic P_PULLUP = 1'b0;
`endif
    // Input unregistered, output disabled; D_IN_0 is the raw pin level.
    SB_IO #(
        .PIN_TYPE (6'b0000_01),
        .PULLUP   (P_PULLUP)
    ) u_io (
        .PACKAGE_PIN (pin),
        .D_IN_0      (w_pin_in)
    );
`else
    assign w_pin_in = pin;
`endif

    // Synchronizer chain: shift the raw pin level through SYNC_STAGES flops.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a real shift chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{INIT_VALUE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_pin_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive
    // differing samples; strobes are registered alongside the level.
    // NOTE: strobes default low at the top of the branch so each one lasts
    // exactly one cycle without a separate clearing path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_value <= INIT_VALUE;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_sync == r_value) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_value <= w_sync;
                r_cnt   <= '0;
                r_rise  <= w_sync;
                r_fall  <= !w_sync;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign value = r_value;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: tb/tb_debounced_input.sv
// Directed bench for debounced_input with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// A second instance with INIT_VALUE=1 shares clock and reset.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_debounced_input;

    logic clk = 1'b0;
    logic rst_n;
    logic pin;
    logic value, rise, fall;
    logic pin2;
    logic value2, rise2, fall2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    debounced_input #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .INIT_VALUE      (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (pin),
        .value (value),
        .rise  (rise),
        .fall  (fall)
    );

    debounced_input #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .INIT_VALUE      (1'b1)
    ) dut_init1 (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (pin2),
        .value (value2),
        .rise  (rise2),
        .fall  (fall2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Called right after the pin has been stepped to new_val (value holds
    // !new_val). Expect five quiet cycles, the change with its strobe on the
    // sixth, and the strobe gone on the seventh.
    task automatic watch_step(input string tag, input logic new_val);
        for (int i = 1; i <= 7; i++) begin
            cycle();
            if (i < 6) begin
                check({tag, "_hold_value"}, value, !new_val);
                check({tag, "_hold_rise"}, rise, 1'b0);
                check({tag, "_hold_fall"}, fall, 1'b0);
            end else if (i == 6) begin
                check({tag, "_edge_value"}, value, new_val);
                check({tag, "_edge_rise"}, rise, new_val);
                check({tag, "_edge_fall"}, fall, !new_val);
            end else begin
                check({tag, "_after_value"}, value, new_val);
                check({tag, "_after_rise"}, rise, 1'b0);
                check({tag, "_after_fall"}, fall, 1'b0);
            end
        end
    endtask

    initial begin
        int n_fall;
        rst_n = 1'b0;
        pin   = 1'b1;
        pin2  = 1'b1;

        // 1. Reset held with pin high: value stays at INIT_VALUE, no strobes.
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_value", value, 1'b0);
            check("rst_rise", rise, 1'b0);
            check("rst_fall", fall, 1'b0);
            check("rst_value_init1", value2, 1'b1);
        end
        rst_n = 1'b1;
        watch_step("post_rst_rise", 1'b1);

        // 4a. Held step 1->0: fall after six clocks.
        pin = 1'b0;
        watch_step("step_fall", 1'b0);

        // 2. Held step 0->1: rise after six clocks, no fall.
        pin = 1'b1;
        watch_step("step_rise", 1'b1);

        // 4b. Chatter 0,1,0,1 at one-cycle spacing: no change, count restarts.
        for (int i = 0; i < 4; i++) begin
            pin = (i % 2 == 0) ? 1'b0 : 1'b1;
            cycle();
            check("chatter_value", value, 1'b1);
            check("chatter_fall", fall, 1'b0);
        end
        pin = 1'b0;
        watch_step("chatter_settle", 1'b0);

        // 3. Three-cycle glitch is rejected.
        pin = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (i == 3) pin = 1'b0;
            check("glitch_value", value, 1'b0);
            check("glitch_rise", rise, 1'b0);
        end

        // 3b. Four-cycle pulse is accepted on the sixth edge, then falls back.
        pin = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            if (i == 4) pin = 1'b0;
            check("pulse_value", value, (i == 6) ? 1'b1 : 1'b0);
            check("pulse_rise", rise, (i == 6) ? 1'b1 : 1'b0);
        end
        n_fall = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (fall) n_fall++;
            check("pulse_no_rise", rise, 1'b0);
        end
        check("pulse_fall_count", n_fall, 1);
        check("pulse_end_value", value, 1'b0);

        // 5. Reset at counter==3 with pin differing discards the progress.
        pin = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        check("midcnt_pre_value", value, 1'b0);
        rst_n = 1'b0;
        cycle();
        check("midcnt_rst_value", value, 1'b0);
        check("midcnt_rst_rise", rise, 1'b0);
        rst_n = 1'b1;
        watch_step("midcnt_restart", 1'b1);

        // 6. INIT_VALUE=1 instance with pin high: no rise after release.
        rst_n = 1'b0;
        cycle();
        cycle();
        check("init1_rst_value", value2, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("init1_value", value2, 1'b1);
            check("init1_rise", rise2, 1'b0);
            check("init1_fall", fall2, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
